// File: rtl/axis_kernel_stream_driver.sv
// Drives one generated message into an AXI-Stream kernel and collects its result stream.
// Optional build macro STALL_INJECT_EN throttles the result sink one cycle in four.
module axis_kernel_stream_driver #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic [7:0]        msg_len,
    input  logic [DATA_W-1:0] seed,
    input  logic              clear_err,
    output logic              input_stream_TVALID,
    input  logic              input_stream_TREADY,
    output logic [DATA_W-1:0] input_stream_TDATA,
    output logic              input_stream_TLAST,
    input  logic              output_stream_TVALID,
    output logic              output_stream_TREADY,
    input  logic [DATA_W-1:0] output_stream_TDATA,
    input  logic              output_stream_TLAST,
    output logic              busy,
    output logic              done,
    output logic              deadlock,
    output logic [7:0]        rx_count,
    output logic [DATA_W-1:0] rx_xor
);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StRecv,
        StDone,
        StErr
    } state_e;

    localparam int unsigned    WdW     = 16;
    localparam logic [WdW-1:0] WdMax   = WdW'(TIMEOUT);
    localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [7:0]          len_q, len_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [7:0]          idx_q, idx_d;
    logic [WdW-1:0]      wd_q, wd_d;
    logic [7:0]          rx_count_q, rx_count_d;
    logic [DATA_W-1:0]   rx_xor_q, rx_xor_d;

    logic                stall;
    logic                src_hs;
    logic                snk_hs;
    logic                last_idx;
    logic [WdW-1:0]      wd_inc;

`ifdef STALL_INJECT_EN
    logic [1:0] stall_cnt_q;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            stall_cnt_q <= 2'd0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 2'd1;
        end
    end

    assign stall = (stall_cnt_q == 2'd3);
`else
    assign stall = 1'b0;
`endif

    assign last_idx = (idx_q == (len_q - 8'd1));
    assign src_hs   = (state_q == StSend) && input_stream_TREADY;
    assign snk_hs   = (state_q == StRecv) && !stall && output_stream_TVALID;
    assign wd_inc   = (wd_q >= WdMax) ? WdMax : (wd_q + 16'd1);

    // Watchdog defaults to zero, which covers both entry into SEND/RECV and idle states.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        seed_d     = seed_q;
        idx_d      = idx_q;
        wd_d       = '0;
        rx_count_d = rx_count_q;
        rx_xor_d   = rx_xor_q;

        unique case (state_q)
            StIdle: begin
                if (start && (msg_len != 8'd0)) begin
                    state_d    = StSend;
                    len_d      = msg_len;
                    seed_d     = seed;
                    idx_d      = 8'd0;
                    rx_count_d = 8'd0;
                    rx_xor_d   = '0;
                end
            end
            StSend: begin
                if (src_hs) begin
                    idx_d = idx_q + 8'd1;
                    if (last_idx) begin
                        state_d = StRecv;
                    end
                end else if (wd_q >= WdLimit) begin
                    state_d = StErr;
                end else begin
                    wd_d = wd_inc;
                end
            end
            StRecv: begin
                if (snk_hs) begin
                    rx_count_d = (rx_count_q == 8'hFF) ? rx_count_q : (rx_count_q + 8'd1);
                    rx_xor_d   = rx_xor_q ^ output_stream_TDATA;
                    if (output_stream_TLAST) begin
                        state_d = StDone;
                    end
                end else if (wd_q >= WdLimit) begin
                    state_d = StErr;
                end else begin
                    wd_d = wd_inc;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StErr: begin
                if (clear_err) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q    <= StIdle;
            len_q      <= 8'd0;
            seed_q     <= '0;
            idx_q      <= 8'd0;
            wd_q       <= '0;
            rx_count_q <= 8'd0;
            rx_xor_q   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            seed_q     <= seed_d;
            idx_q      <= idx_d;
            wd_q       <= wd_d;
            rx_count_q <= rx_count_d;
            rx_xor_q   <= rx_xor_d;
        end
    end

    // Source outputs are gated to zero outside SEND so reset and idle present a clean bus.
    always_comb begin
        input_stream_TVALID  = 1'b0;
        input_stream_TDATA   = '0;
        input_stream_TLAST   = 1'b0;
        output_stream_TREADY = 1'b0;
        if (state_q == StSend) begin
            input_stream_TVALID = 1'b1;
            input_stream_TDATA  = seed_q + DATA_W'(idx_q);
            input_stream_TLAST  = last_idx;
        end
        if (state_q == StRecv) begin
            output_stream_TREADY = !stall;
        end
    end

    assign busy     = (state_q == StSend) || (state_q == StRecv);
    assign done     = (state_q == StDone);
    assign deadlock = (state_q == StErr);
    assign rx_count = rx_count_q;
    assign rx_xor   = rx_xor_q;

endmodule

// File: tb/tb_axis_kernel_stream_driver.sv
// Directed self-checking bench for axis_kernel_stream_driver (TIMEOUT=8).
module tb_axis_kernel_stream_driver;

    localparam int unsigned DW = 64;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    msg_len = 8'd0;
    logic [DW-1:0] seed = '0;
    logic          clear_err = 1'b0;
    logic          in_tvalid;
    logic          in_tready = 1'b0;
    logic [DW-1:0] in_tdata;
    logic          in_tlast;
    logic          out_tvalid = 1'b0;
    logic          out_tready;
    logic [DW-1:0] out_tdata = '0;
    logic          out_tlast = 1'b0;
    logic          busy, done, deadlock;
    logic [7:0]    rx_count;
    logic [DW-1:0] rx_xor;

    int tests = 0;
    int fails = 0;

    axis_kernel_stream_driver #(.DATA_W(DW), .TIMEOUT(8)) dut (
        .ap_clk               (ap_clk),
        .ap_rst_n             (ap_rst_n),
        .start                (start),
        .msg_len              (msg_len),
        .seed                 (seed),
        .clear_err            (clear_err),
        .input_stream_TVALID  (in_tvalid),
        .input_stream_TREADY  (in_tready),
        .input_stream_TDATA   (in_tdata),
        .input_stream_TLAST   (in_tlast),
        .output_stream_TVALID (out_tvalid),
        .output_stream_TREADY (out_tready),
        .output_stream_TDATA  (out_tdata),
        .output_stream_TLAST  (out_tlast),
        .busy                 (busy),
        .done                 (done),
        .deadlock             (deadlock),
        .rx_count             (rx_count),
        .rx_xor               (rx_xor)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Offers one result word and waits (bounded) for the sink to accept it.
    task automatic recv_word(input logic [DW-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        out_tvalid = 1'b1;
        out_tdata  = d;
        out_tlast  = l;
        for (int k = 0; k < 4 && !ok; k++) begin
            if (out_tready) ok = 1'b1;
            tick();
        end
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL recv_accept: word %h not accepted, got tready=0 required 1", d);
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        tick();
        tick();
        tests++;
        if ({in_tvalid, out_tready, in_tlast, busy, done, deadlock} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b required 000000",
                     {in_tvalid, out_tready, in_tlast, busy, done, deadlock});
        end
        tests++;
        if (in_tdata !== '0 || rx_count !== 8'd0 || rx_xor !== '0) begin
            fails++;
            $display("FAIL reset_data: got tdata=%h cnt=%0d xor=%h required 0", in_tdata,
                     rx_count, rx_xor);
        end
        ap_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_send();
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 64'h10;
        exp_d[1] = 64'h11;
        exp_d[2] = 64'h12;
        in_tready = 1'b1;
        start = 1'b1;
        msg_len = 8'd3;
        seed = 64'h10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (in_tvalid !== 1'b1 || in_tdata !== exp_d[i] || in_tlast !== (i == 2) ||
                busy !== 1'b1) begin
                fails++;
                $display("FAIL send_word%0d: got v=%b d=%h l=%b busy=%b required v=1 d=%h l=%b",
                         i, in_tvalid, in_tdata, in_tlast, busy, exp_d[i], (i == 2));
            end
            tick();
        end
        in_tready = 1'b0;
        tests++;
        if (in_tvalid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL send_to_recv: got tvalid=%b busy=%b required 0 1", in_tvalid, busy);
        end
    endtask

    task automatic test_recv();
        int lows;
        int exp_lows;
        lows = 0;
`ifdef STALL_INJECT_EN
        exp_lows = 1;
`else
        exp_lows = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            if (!out_tready) lows++;
            tick();
        end
        tests++;
        if (lows !== exp_lows) begin
            fails++;
            $display("FAIL recv_tready_pattern: got %0d low cycles required %0d", lows, exp_lows);
        end
        recv_word(64'hA, 1'b0);
        recv_word(64'h5, 1'b0);
        recv_word(64'hF, 1'b1);
        tests++;
        if (done !== 1'b1 || rx_count !== 8'd3 || rx_xor !== 64'h0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL recv_done: got done=%b cnt=%0d xor=%h busy=%b required 1 3 0 0",
                     done, rx_count, rx_xor, busy);
        end
        tick();
        tests++;
        if (done !== 1'b0 || rx_count !== 8'd3 || out_tready !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: got done=%b cnt=%0d tready=%b required 0 3 0",
                     done, rx_count, out_tready);
        end
    endtask

    task automatic test_deadlock();
        in_tready = 1'b0;
        start = 1'b1;
        msg_len = 8'd2;
        seed = 64'h0;
        tick();
        start = 1'b0;
        repeat (7) tick();
        tests++;
        if (busy !== 1'b1 || deadlock !== 1'b0) begin
            fails++;
            $display("FAIL deadlock_early: got busy=%b deadlock=%b required 1 0", busy, deadlock);
        end
        tick();
        tests++;
        if (deadlock !== 1'b1 || in_tvalid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL deadlock_set: got deadlock=%b tvalid=%b busy=%b required 1 0 0",
                     deadlock, in_tvalid, busy);
        end
        start = 1'b1;
        msg_len = 8'd1;
        tick();
        start = 1'b0;
        tests++;
        if (deadlock !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL err_ignores_start: got deadlock=%b busy=%b required 1 0",
                     deadlock, busy);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        tests++;
        if (deadlock !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL clear_err: got deadlock=%b busy=%b required 0 0", deadlock, busy);
        end
    endtask

    task automatic test_timeout_race();
        in_tready = 1'b0;
        start = 1'b1;
        msg_len = 8'd2;
        seed = 64'h20;
        tick();
        start = 1'b0;
        repeat (7) tick();
        in_tready = 1'b1;
        tick();
        in_tready = 1'b0;
        tests++;
        if (deadlock !== 1'b0 || busy !== 1'b1 || in_tdata !== 64'h21 || in_tlast !== 1'b1) begin
            fails++;
            $display("FAIL race_handshake_wins: got deadlock=%b busy=%b d=%h l=%b required 0 1 21 1",
                     deadlock, busy, in_tdata, in_tlast);
        end
        repeat (7) tick();
        tests++;
        if (deadlock !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL race_wd_cleared: got deadlock=%b busy=%b required 0 1", deadlock, busy);
        end
        in_tready = 1'b1;
        tick();
        in_tready = 1'b0;
        recv_word(64'h3, 1'b1);
        tests++;
        if (done !== 1'b1 || rx_count !== 8'd1 || rx_xor !== 64'h3) begin
            fails++;
            $display("FAIL race_done: got done=%b cnt=%0d xor=%h required 1 1 3",
                     done, rx_count, rx_xor);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        start = 1'b1;
        msg_len = 8'd0;
        seed = 64'h55;
        tick();
        start = 1'b0;
        tests++;
        if (busy !== 1'b0 || rx_count !== 8'd1 || rx_xor !== 64'h3) begin
            fails++;
            $display("FAIL zero_len_ignored: got busy=%b cnt=%0d xor=%h required 0 1 3",
                     busy, rx_count, rx_xor);
        end
        in_tready = 1'b0;
        start = 1'b1;
        msg_len = 8'd2;
        seed = 64'h40;
        tick();
        msg_len = 8'd5;
        seed = 64'h99;
        tick();
        start = 1'b0;
        tests++;
        if (in_tdata !== 64'h40 || in_tlast !== 1'b0 || in_tvalid !== 1'b1) begin
            fails++;
            $display("FAIL busy_start_ignored: got d=%h l=%b v=%b required 40 0 1",
                     in_tdata, in_tlast, in_tvalid);
        end
        in_tready = 1'b1;
        tick();
        tests++;
        if (in_tdata !== 64'h41 || in_tlast !== 1'b1) begin
            fails++;
            $display("FAIL busy_len_kept: got d=%h l=%b required 41 1", in_tdata, in_tlast);
        end
        tick();
        in_tready = 1'b0;
    endtask

    task automatic test_reset_mid_recv();
        tests++;
        if (busy !== 1'b1 || in_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL in_recv: got busy=%b tvalid=%b required 1 0", busy, in_tvalid);
        end
        out_tvalid = 1'b1;
        out_tdata = 64'h77;
        out_tlast = 1'b1;
        ap_rst_n = 1'b0;
        tick();
        out_tvalid = 1'b0;
        out_tlast = 1'b0;
        tests++;
        if ({in_tvalid, out_tready, in_tlast, busy, done, deadlock} !== 6'b0 ||
            rx_count !== 8'd0 || rx_xor !== '0 || in_tdata !== '0) begin
            fails++;
            $display("FAIL reset_mid_recv: got flags=%b cnt=%0d xor=%h required 000000 0 0",
                     {in_tvalid, out_tready, in_tlast, busy, done, deadlock}, rx_count, rx_xor);
        end
        ap_rst_n = 1'b1;
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_done: got done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_count_saturate();
        logic [DW-1:0] exp_x;
        exp_x = '0;
        in_tready = 1'b1;
        start = 1'b1;
        msg_len = 8'd1;
        seed = 64'h5;
        tick();
        start = 1'b0;
        tests++;
        if (in_tdata !== 64'h5 || in_tlast !== 1'b1) begin
            fails++;
            $display("FAIL single_word: got d=%h l=%b required 5 1", in_tdata, in_tlast);
        end
        tick();
        in_tready = 1'b0;
        for (int i = 0; i < 260; i++) begin
            recv_word(DW'(i + 1), 1'b0);
            exp_x = exp_x ^ DW'(i + 1);
        end
        tests++;
        if (rx_count !== 8'd255 || rx_xor !== exp_x || busy !== 1'b1) begin
            fails++;
            $display("FAIL count_saturate: got cnt=%0d xor=%h busy=%b required 255 %h 1",
                     rx_count, rx_xor, busy, exp_x);
        end
        recv_word(64'h0, 1'b1);
        tests++;
        if (done !== 1'b1 || rx_count !== 8'd255) begin
            fails++;
            $display("FAIL saturate_done: got done=%b cnt=%0d required 1 255", done, rx_count);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_send();
        test_recv();
        test_deadlock();
        test_timeout_race();
        test_ignore_start();
        test_reset_mid_recv();
        test_count_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_kernel_stream_driver.md
AXIS_KERNEL_STREAM_DRIVER -- requirements
Module: axis_kernel_stream_driver

Interface
REQ-001 The block SHALL have these parameters: DATA_W, default 64, stream word width; TIMEOUT, default 1024, stall cycles before deadlock is declared (range 2..65535).
REQ-002 The block SHALL have these ports:
- ap_clk  in  1  single clock; all logic on its rising edge
- ap_rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to run one message
- msg_len  in  8  number of words to send, sampled at start
- seed  in  DATA_W  first data word, sampled at start
- clear_err  in  1  one-cycle pulse that leaves ERR
- input_stream_TVALID  out  1  source valid toward kernel
- input_stream_TREADY  in  1  kernel ready
- input_stream_TDATA  out  DATA_W  source data
- input_stream_TLAST  out  1  last source word
- output_stream_TVALID  in  1  kernel result valid
- output_stream_TREADY  out  1  sink ready
- output_stream_TDATA  in  DATA_W  result data
- output_stream_TLAST  in  1  last result word
- busy  out  1  high in SEND or RECV
- done  out  1  one-cycle pulse at message completion
- deadlock  out  1  sticky stall flag
- rx_count  out  8  result words accepted in the last or current message
- rx_xor  out  DATA_W  XOR of all result words accepted in the message

Function
REQ-003 The FSM SHALL have the states IDLE, SEND, RECV, DONE and ERR.
REQ-004 In IDLE, start=1 with msg_len!=0 SHALL latch msg_len and seed, clear idx, rx_count and rx_xor, and enter SEND next cycle; start with msg_len=0 SHALL be ignored.
REQ-005 start SHALL be ignored in every state except IDLE.
REQ-006 In SEND, TVALID SHALL be 1, TDATA SHALL be seed+idx (modulo 2^DATA_W), and TLAST SHALL be 1 when idx==msg_len-1.
REQ-007 TDATA, TLAST and TVALID SHALL stay stable while TVALID=1 and TREADY=0.
REQ-008 A source handshake (TVALID&TREADY) SHALL increment idx; a handshake with TLAST=1 SHALL enter RECV next cycle.
REQ-009 output_stream_TREADY SHALL be 0 outside RECV.
REQ-010 In RECV, each sink handshake SHALL increment rx_count, saturating at 255, and XOR TDATA into rx_xor.
REQ-011 A sink handshake with TLAST=1 SHALL enter DONE; DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-012 The watchdog counter SHALL clear on entry to SEND or RECV and on every handshake of the active stream, and SHALL otherwise increment in SEND or RECV, saturating at TIMEOUT.
REQ-013 When the watchdog reaches TIMEOUT-1 without a handshake in that cycle, the FSM SHALL enter ERR and set deadlock.
REQ-014 A handshake in the same cycle as the timeout SHALL win: no ERR is entered.
REQ-015 In ERR, TVALID and TREADY SHALL be 0 and deadlock SHALL stay 1; clear_err SHALL clear deadlock and return to IDLE.
REQ-016 busy SHALL be high exactly in SEND and RECV; rx_count and rx_xor SHALL hold their values until the next accepted start.

Reset
REQ-017 With ap_rst_n=0 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 (TVALID, TREADY, TDATA, TLAST, busy, done, deadlock, rx_count, rx_xor); idx and the watchdog SHALL clear.
REQ-018 Reset asserted during SEND, RECV or ERR SHALL abort the message with no done pulse.

Configuration
REQ-019 When STALL_INJECT_EN is defined, output_stream_TREADY in RECV SHALL be 0 whenever a free-running 2-bit counter (reset to 0) equals 3, and 1 otherwise; these injected-stall cycles SHALL still advance the watchdog.
REQ-020 When STALL_INJECT_EN is not defined, output_stream_TREADY SHALL be 1 throughout RECV.

Verification
REQ-021 start, msg_len=3, seed=0x10, TREADY=1 -> TDATA 0x10,0x11,0x12 on consecutive cycles, TLAST only on 0x12, then RECV.
REQ-022 In RECV, kernel returns 0xA,0x5,0xF with TLAST on 0xF -> rx_count=3, rx_xor=0x0, one-cycle done pulse, IDLE.
REQ-023 TIMEOUT=8, input_stream_TREADY held 0 in SEND -> deadlock=1 and ERR after 8 cycles, TVALID=0; clear_err -> IDLE with deadlock=0.
REQ-024 TIMEOUT=8, handshake exactly on the timeout cycle -> no ERR, watchdog cleared.
REQ-025 start with msg_len=0, or start while busy -> ignored, state unchanged.
REQ-026 ap_rst_n=0 mid-RECV -> all outputs 0 next cycle, no done pulse; with STALL_INJECT_EN defined, TREADY low every 4th cycle in RECV.
